axi_wb_stream_burst: RTL
========================

// Module: axi_wb_stream_burst
// PURPOSE
//  Parametrised AXI4 write-burst master. It drains a ready/valid data stream into memory, starting at base_addr, for len beats.
//  The transfer is split automatically into INCR bursts of at most MAX_BURST beats; no burst crosses a 4 KB boundary.
//  Every B response is waited for before the next burst is issued. Sits between an HLS-generated kernel (stream producer) and the AXI interconnect.
// PARAMETERS
//  ADDR_W     16  AXI byte-address width (>=13)
//  DATA_W     32  data width in bits; power of 2, 8..1024
//  LEN_W      16  width of total transfer length in beats
//  MAX_BURST  16  beats per burst; 1..256
// PORTS
//  clk          in   1       single clock; all logic on rising edge
//  rst          in   1       reset: asynchronous assert, active-low
//  start        in   1       pulse; accepted only when !busy
//  base_addr    in   ADDR_W  start byte address; low log2(DATA_W/8) bits forced to 0
//  len          in   LEN_W   total beats to write
//  busy         out  1       high from accepted start until done
//  done         out  1       high after completion, held until next accepted start
//  err          out  1       sticky error flag (see CONFIGURATION)
//  s_data       in   DATA_W  stream data
//  s_valid      in   1       stream data valid
//  s_ready      out  1       stream pop; a beat transfers when s_valid&&s_ready
//  m_awaddr     out  ADDR_W  burst address
//  m_awlen      out  8       beats-1
//  m_awsize     out  3       log2(DATA_W/8), constant
//  m_awburst    out  2       2'b01 INCR, constant
//  m_awvalid    out  1
//  m_awready    in   1
//  m_wdata      out  DATA_W  = s_data (combinational pass-through)
//  m_wstrb      out  DATA_W/8  all ones
//  m_wlast      out  1       high on final beat of burst
//  m_wvalid     out  1       = s_valid in S_W
//  m_wready     in   1
//  m_bresp      in   2
//  m_bvalid     in   1
//  m_bready     out  1       high in S_B only
// BEHAVIOUR
//  Reset: state S_IDLE, busy=0, done=0, err=0, every valid/ready output 0, address/counters 0.
//  FSM states:
//   S_IDLE: on start: latch addr/len, clear done and err. len==0 -> S_DONE; else -> S_AW.
//   S_AW: awvalid=1; awaddr/awlen held stable. On awready -> S_W, beat counter = awlen.
//   S_W: s_ready=m_wready, m_wvalid=s_valid. Each handshake decrements the counter.
//     m_wlast = (counter==0). The wlast handshake -> S_B.
//   S_B: bready=1. On bvalid: addr += beats*DATA_W/8, remaining -= beats.
//     remaining==0 -> S_DONE; else -> S_AW.
//   S_DONE: done=1, busy=0 -> S_IDLE in the same cycle. done stays high in S_IDLE until the next start.
//  Burst size: beats = min(remaining, MAX_BURST, (4096 - addr[11:0]) >> log2(DATA_W/8)).
//   Computed in S_B / on start and registered before entering S_AW.
//   awlen = beats-1 (8 bits). Address wraps modulo 2^ADDR_W.
//  Latency: start -> awvalid is 1 cycle. awready in cycle N -> first wvalid possible in cycle N+1.
//  AW, W and B are strictly sequential; one burst is outstanding at most. The stream is never popped outside S_W.
//  start while busy: ignored. start in the same cycle as S_DONE: ignored (busy still 1).
//  Stream stall (s_valid=0) or slave stall (wready=0): hold state, no beat lost or duplicated.
//  Reset mid-burst: immediate return to reset values. AXI protocol completion is not guaranteed; the system resets the slave together with this block.
// CONFIGURATION
//  AXI_WB_STREAM_BRESP_CHECK_EN defined:
//   bresp != 2'b00 sets err and aborts; remaining bursts are skipped -> S_DONE.
//  AXI_WB_STREAM_BRESP_CHECK_EN undefined:
//   bresp ignored; err tied 0; all bursts always issued.
// STRUCTURE
//  Package axi_wb_pkg holds:
//   state typedef (S_IDLE,S_AW,S_W,S_B,S_DONE)
//   AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00, AXI_4K=4096
//   function clog2
//  Sub-module axi_wb_burst_calc: combinational min(remaining, MAX_BURST, bytes-to-4K) -> beats.
//  Top holds the FSM, counters and registers.
// TESTING
//  1. DATA_W=32, MAX_BURST=16, base=0x0000, len=40
//     -> bursts at 0x0000/0x0040/0x0080, awlen 15/15/7; 40 beats in order; done=1.
//  2. base=0x0FF8, len=8
//     -> bursts 0x0FF8 awlen=1, then 0x1000 awlen=5; no 4K crossing.
//  3. len=0
//     -> no awvalid/wvalid ever; done=1 two cycles after start.
//  4. Random s_valid/m_wready stalls (50%), len=33
//     -> scoreboard sees exactly 33 beats, wlast exactly on beats 16, 32 and 33.
//  5. With the macro defined, bresp=2'b10 on the first burst of len=40
//     -> err=1, done=1, no second awvalid. With the macro undefined -> 3 bursts, err=0.
//  6. rst low during S_W -> next cycle all valids 0, busy=0; a new start afterwards completes normally.

Source files
------------

// File: rtl/axi_wb_pkg.sv
// rtl/axi_wb_pkg.sv - shared state type, AXI constants and clog2 helper for the stream-to-AXI burst writer
package axi_wb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_DONE
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         AXI_4K         = 4096;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/axi_wb_stream_burst_if.sv
// rtl/axi_wb_stream_burst_if.sv - stream input plus AXI4 write-channel bundle for the burst writer
interface axi_wb_stream_burst_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);

  logic [DATA_W-1:0]   s_data;
  logic                s_valid;
  logic                s_ready;

  logic [ADDR_W-1:0]   m_awaddr;
  logic [7:0]          m_awlen;
  logic [2:0]          m_awsize;
  logic [1:0]          m_awburst;
  logic                m_awvalid;
  logic                m_awready;

  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W/8-1:0] m_wstrb;
  logic                m_wlast;
  logic                m_wvalid;
  logic                m_wready;

  logic [1:0]          m_bresp;
  logic                m_bvalid;
  logic                m_bready;

  modport master (
    input  s_data, s_valid,
    output s_ready,
    output m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    input  m_awready,
    output m_wdata, m_wstrb, m_wlast, m_wvalid,
    input  m_wready,
    input  m_bresp, m_bvalid,
    output m_bready
  );

  modport slave (
    output s_data, s_valid,
    input  s_ready,
    input  m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    output m_awready,
    input  m_wdata, m_wstrb, m_wlast, m_wvalid,
    output m_wready,
    output m_bresp, m_bvalid,
    input  m_bready
  );

endinterface

// File: rtl/axi_wb_burst_calc.sv
// rtl/axi_wb_burst_calc.sv - next burst length: min(remaining, MAX_BURST, beats left before the 4 KB boundary)
module axi_wb_burst_calc
  import axi_wb_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 16,
  parameter int MAX_BURST = 16
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LEN_W-1:0]  remaining_i,
  output logic [8:0]        beats_o
);

  localparam int SZ = clog2(DATA_W / 8);
  localparam int CW = (LEN_W > 13) ? LEN_W : 13;

  logic [12:0]   to_4k_bytes;
  logic [CW-1:0] to_4k_c;
  logic [CW-1:0] rem_c;
  logic [CW-1:0] min_c;

  // Address is beat-aligned, so the byte distance divides exactly into beats.
  assign to_4k_bytes = 13'(AXI_4K) - {1'b0, 12'(addr_i)};
  assign to_4k_c     = CW'(to_4k_bytes >> SZ);
  assign rem_c       = CW'(remaining_i);

  always_comb begin
    min_c = CW'(MAX_BURST);
    if (to_4k_c < min_c) min_c = to_4k_c;
    if (rem_c < min_c)   min_c = rem_c;
  end

  assign beats_o = 9'(min_c);

endmodule

// File: rtl/axi_wb_stream_burst.sv
// rtl/axi_wb_stream_burst.sv - drains a ready/valid stream into memory as 4K-safe AXI4 INCR write bursts
// Optional: AXI_WB_STREAM_BRESP_CHECK_EN makes a non-OKAY bresp set err and abort the transfer.
module axi_wb_stream_burst
  import axi_wb_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 16,
  parameter int MAX_BURST = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_W-1:0]     base_addr_i,
  input  logic [LEN_W-1:0]      len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  axi_wb_stream_burst_if.master bus
);

  localparam int SZ = clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << SZ) - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [8:0]        beats_q, beats_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] next_addr, calc_addr;
  logic [LEN_W-1:0]  next_rem, calc_rem;
  logic [8:0]        calc_beats;
  logic [7:0]        awlen;
  logic              bresp_bad;

  // Address and remaining count as they will be once the current burst is acknowledged.
  assign next_addr = addr_q + (ADDR_W'(beats_q) << SZ);
  assign next_rem  = rem_q - LEN_W'(beats_q);
  assign calc_addr = (state_q == S_IDLE) ? (base_addr_i & ALIGN_MASK) : next_addr;
  assign calc_rem  = (state_q == S_IDLE) ? len_i : next_rem;
  assign awlen     = 8'(beats_q - 9'd1);

  axi_wb_burst_calc #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .LEN_W    (LEN_W),
    .MAX_BURST(MAX_BURST)
  ) u_calc (
    .addr_i     (calc_addr),
    .remaining_i(calc_rem),
    .beats_o    (calc_beats)
  );

`ifdef AXI_WB_STREAM_BRESP_CHECK_EN
  assign bresp_bad = (bus.m_bresp != AXI_RESP_OKAY);
`else
  logic unused_bresp;
  assign unused_bresp = ^bus.m_bresp;
  assign bresp_bad    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    beats_d = beats_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d  = calc_addr;
          rem_d   = len_i;
          beats_d = calc_beats;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = (len_i == '0) ? S_DONE : S_AW;
        end
      end
      S_AW: begin
        if (bus.m_awready) begin
          cnt_d   = awlen;
          state_d = S_W;
        end
      end
      S_W: begin
        if (bus.s_valid && bus.m_wready) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd0) state_d = S_B;
        end
      end
      S_B: begin
        if (bus.m_bvalid) begin
          addr_d  = next_addr;
          rem_d   = next_rem;
          beats_d = calc_beats;
          if (bresp_bad) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (next_rem == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_AW;
          end
        end
      end
      S_DONE: begin
        // busy/done flip on the way out so a start seen here is still ignored.
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      beats_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      beats_q <= beats_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;

  assign bus.m_awaddr  = addr_q;
  assign bus.m_awlen   = awlen;
  assign bus.m_awsize  = 3'(SZ);
  assign bus.m_awburst = AXI_BURST_INCR;
  assign bus.m_awvalid = (state_q == S_AW);
  assign bus.m_wdata   = bus.s_data;
  assign bus.m_wstrb   = '1;
  assign bus.m_wvalid  = (state_q == S_W) && bus.s_valid;
  assign bus.s_ready   = (state_q == S_W) && bus.m_wready;
  assign bus.m_wlast   = (state_q == S_W) && (cnt_q == 8'd0);
  assign bus.m_bready  = (state_q == S_B);

endmodule
